// File: rtl/gate_array_filt.sv
// Bank of CHANNELS two-input gates with a run-time selectable function.
// Each A/B bit is synchronised, each gate result is glitch-filtered, and every output is registered.
module gate_array_filt #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = $clog2(FILT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] A,
  input  logic [CHANNELS-1:0] B,
  input  logic [2:0]          mode_in,
  input  logic                mode_load,
  input  logic                oe,
  output logic [CHANNELS-1:0] Y,
  output logic                Y_oe,
  output logic [CHANNELS-1:0] chg,
  output logic [2:0]          mode
);

  typedef enum logic [2:0] {
    FN_NAND  = 3'd0,
    FN_AND   = 3'd1,
    FN_OR    = 3'd2,
    FN_NOR   = 3'd3,
    FN_XOR   = 3'd4,
    FN_XNOR  = 3'd5,
    FN_NOT_A = 3'd6,
    FN_BUF_A = 3'd7
  } gate_fn_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [CHANNELS-1:0] sync_a [SYNC_STAGES];
  logic [CHANNELS-1:0] sync_b [SYNC_STAGES];
  logic [CHANNELS-1:0] s_a;
  logic [CHANNELS-1:0] s_b;
  logic [CHANNELS-1:0] r;
  logic [CNT_W-1:0]    cnt [CHANNELS];
  gate_fn_t            mode_q;

  // Synchroniser chains for the asynchronous pad inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_a[s] <= '0;
        sync_b[s] <= '0;
      end
    end else begin
      sync_a[0] <= A;
      sync_b[0] <= B;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_a[s] <= sync_a[s-1];
        sync_b[s] <= sync_b[s-1];
      end
    end
  end

  assign s_a = sync_a[SYNC_STAGES-1];
  assign s_b = sync_b[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= FN_NAND;
    end else if (mode_load) begin
      mode_q <= gate_fn_t'(mode_in);
    end
  end

  assign mode = mode_q;

  always_comb begin
    r = '0;
    case (mode_q)
      FN_NAND:  r = ~(s_a & s_b);
      FN_AND:   r = s_a & s_b;
      FN_OR:    r = s_a | s_b;
      FN_NOR:   r = ~(s_a | s_b);
      FN_XOR:   r = s_a ^ s_b;
      FN_XNOR:  r = ~(s_a ^ s_b);
      FN_NOT_A: r = ~s_a;
      FN_BUF_A: r = s_a;
    endcase
  end

  // A mode load restarts every filter and holds Y, even if a channel was about to expire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
      Y   <= '1;
      chg <= '0;
    end else if (mode_load) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
      chg <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        chg[i] <= 1'b0;
        if (r[i] == Y[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          Y[i]   <= r[i];
          cnt[i] <= '0;
          chg[i] <= 1'b1;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_oe <= 1'b0;
    end else begin
      Y_oe <= oe;
    end
  end

endmodule

// File: tb/tb_gate_array_filt.sv
// Directed self-checking bench for gate_array_filt: default instance plus an
// 8-channel, 3-stage, single-cycle-filter instance for the parametrised latency.
module tb_gate_array_filt;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic [2:0] mode_in;
  logic       mode_load, oe;
  logic [3:0] y, chg;
  logic       y_oe;
  logic [2:0] mode;

  logic [7:0] a2, b2, y2, chg2;
  logic       y_oe2;
  logic [2:0] mode2;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results for A=0011, B=0101 under function codes 0..7.
  logic [3:0] fn_tab [8] = '{4'b1110, 4'b0001, 4'b0111, 4'b1000,
                             4'b0110, 4'b1001, 4'b1100, 4'b0011};
  int         order  [8] = '{4, 0, 1, 2, 3, 5, 6, 7};

  always #5 clk = ~clk;

  gate_array_filt dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .mode_in(mode_in),
    .mode_load(mode_load), .oe(oe), .Y(y), .Y_oe(y_oe), .chg(chg), .mode(mode)
  );

  gate_array_filt #(.CHANNELS(8), .SYNC_STAGES(3), .FILT_CYCLES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .mode_in(3'd0),
    .mode_load(1'b0), .oe(1'b0), .Y(y2), .Y_oe(y_oe2), .chg(chg2), .mode(mode2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] na, input logic [3:0] nb);
    a = na;
    b = nb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; applyStimulus(4'hF, 4'hF); oe = 1'b1;
    mode_load = 1'b0; mode_in = 3'd0; a2 = '0; b2 = '0;
    tick(); tick();
    n_checks++; if (y !== 4'hF) begin n_fail++; $display("[TB] FAIL reset_y: got %b want 1111", y); end
    n_checks++; if (chg !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_chg: got %b want 0000", chg); end
    n_checks++; if (mode !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_mode: got %0d want 0", mode); end
    n_checks++; if (y_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_y_oe: got %b want 0", y_oe); end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] ey, ec;
      tick();
      ey = (e >= 5) ? 4'h0 : 4'hF;
      ec = (e == 5) ? 4'hF : 4'h0;
      n_checks++; if (y !== ey) begin n_fail++; $display("[TB] FAIL release_y edge %0d: got %b want %b", e, y, ey); end
      n_checks++; if (chg !== ec) begin n_fail++; $display("[TB] FAIL release_chg edge %0d: got %b want %b", e, chg, ec); end
    end
    n_checks++; if (y_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL release_y_oe: got %b want 1", y_oe); end
  endtask

  task automatic test_nand();
    applyStimulus(4'b0011, 4'b0101);
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] ey, ec;
      tick();
      ey = (e >= 5) ? 4'b1110 : 4'b0000;
      ec = (e == 5) ? 4'b1110 : 4'b0000;
      n_checks++; if (y !== ey) begin n_fail++; $display("[TB] FAIL nand_y edge %0d: got %b want %b", e, y, ey); end
      n_checks++; if (chg !== ec) begin n_fail++; $display("[TB] FAIL nand_chg edge %0d: got %b want %b", e, chg, ec); end
    end
  endtask

  task automatic test_glitch();
    applyStimulus(4'b0000, 4'b0000);
    repeat (6) tick();
    n_checks++; if (y !== 4'hF) begin n_fail++; $display("[TB] FAIL glitch_idle_y: got %b want 1111", y); end
    applyStimulus(4'b0010, 4'b0010);
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) applyStimulus(4'b0000, 4'b0000);
      tick();
      n_checks++; if (y !== 4'hF || chg !== 4'h0) begin
        n_fail++; $display("[TB] FAIL glitch2 edge %0d: got y=%b chg=%b want y=1111 chg=0000", e, y, chg);
      end
    end
    for (int e = 1; e <= 9; e++) begin
      logic [3:0] ey, ec;
      if (e == 1) applyStimulus(4'b0010, 4'b0010);
      if (e == 4) applyStimulus(4'b0000, 4'b0000);
      tick();
      ey = (e >= 5 && e < 8) ? 4'b1101 : 4'b1111;
      ec = (e == 5 || e == 8) ? 4'b0010 : 4'b0000;
      n_checks++; if (y !== ey || chg !== ec) begin
        n_fail++; $display("[TB] FAIL glitch3 edge %0d: got y=%b chg=%b want y=%b chg=%b", e, y, chg, ey, ec);
      end
    end
  endtask

  task automatic test_mode();
    logic [3:0] prev;
    applyStimulus(4'b0011, 4'b0101);
    repeat (6) tick();
    n_checks++; if (y !== 4'b1110) begin n_fail++; $display("[TB] FAIL mode_settle_y: got %b want 1110", y); end
    prev = 4'b1110;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] nxt;
      nxt = fn_tab[order[k]];
      mode_in = 3'(order[k]); mode_load = 1'b1;
      tick();
      mode_load = 1'b0;
      n_checks++; if (mode !== 3'(order[k])) begin n_fail++; $display("[TB] FAIL mode_reg code %0d: got %0d", order[k], mode); end
      n_checks++; if (y !== prev || chg !== 4'h0) begin
        n_fail++; $display("[TB] FAIL mode_hold code %0d: got y=%b chg=%b want y=%b chg=0000", order[k], y, chg, prev);
      end
      tick(); tick();
      n_checks++; if (y !== prev) begin n_fail++; $display("[TB] FAIL mode_early code %0d: got %b want %b", order[k], y, prev); end
      tick();
      n_checks++; if (y !== nxt || chg !== (prev ^ nxt)) begin
        n_fail++; $display("[TB] FAIL mode_out code %0d: got y=%b chg=%b want y=%b chg=%b", order[k], y, chg, nxt, prev ^ nxt);
      end
      prev = nxt;
    end
  endtask

  task automatic test_collision();
    mode_in = 3'd0; mode_load = 1'b1;
    tick();
    mode_load = 1'b0;
    repeat (3) tick();
    n_checks++; if (y !== 4'b1110) begin n_fail++; $display("[TB] FAIL coll_setup_y: got %b want 1110", y); end
    applyStimulus(4'b0010, 4'b0101);
    for (int e = 1; e <= 9; e++) begin
      logic [3:0] ey, ec;
      mode_load = (e == 5);
      tick();
      mode_load = 1'b0;
      ey = (e >= 8) ? 4'b1111 : 4'b1110;
      ec = (e == 8) ? 4'b0001 : 4'b0000;
      n_checks++; if (y !== ey || chg !== ec) begin
        n_fail++; $display("[TB] FAIL collision edge %0d: got y=%b chg=%b want y=%b chg=%b", e, y, chg, ey, ec);
      end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(4'b0011, 4'b0101);
    repeat (6) tick();
    n_checks++; if (y !== 4'b1110) begin n_fail++; $display("[TB] FAIL rmid_setup_y: got %b want 1110", y); end
    applyStimulus(4'b0010, 4'b0101);
    repeat (4) tick();
    n_checks++; if (y !== 4'b1110) begin n_fail++; $display("[TB] FAIL rmid_pending_y: got %b want 1110", y); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (y !== 4'hF || chg !== 4'h0 || y_oe !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rmid_async: got y=%b chg=%b y_oe=%b want 1111 0000 0", y, chg, y_oe);
    end
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b0011, 4'b0101);
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] ey, ec;
      tick();
      ey = (e >= 5) ? 4'b1110 : 4'b1111;
      ec = (e == 5) ? 4'b0001 : 4'b0000;
      n_checks++; if (y !== ey || chg !== ec) begin
        n_fail++; $display("[TB] FAIL rmid_refill edge %0d: got y=%b chg=%b want y=%b chg=%b", e, y, chg, ey, ec);
      end
    end
  endtask

  task automatic test_oe();
    oe = 1'b0;
    n_checks++; if (y_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL oe_registered: got %b want 1", y_oe); end
    tick();
    n_checks++; if (y_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL oe_low: got %b want 0", y_oe); end
    oe = 1'b1;
    tick();
    n_checks++; if (y_oe !== 1'b1) begin n_fail++; $display("[TB] FAIL oe_high: got %b want 1", y_oe); end
  endtask

  task automatic test_param();
    n_checks++; if (y2 !== 8'hFF || mode2 !== 3'd0 || y_oe2 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL p8_idle: got y=%h mode=%0d y_oe=%b want ff 0 0", y2, mode2, y_oe2);
    end
    a2 = 8'h33; b2 = 8'h55;
    for (int e = 1; e <= 5; e++) begin
      logic [7:0] ey, ec;
      tick();
      ey = (e >= 4) ? 8'hEE : 8'hFF;
      ec = (e == 4) ? 8'h11 : 8'h00;
      n_checks++; if (y2 !== ey || chg2 !== ec) begin
        n_fail++; $display("[TB] FAIL p8_nand edge %0d: got y=%h chg=%h want y=%h chg=%h", e, y2, chg2, ey, ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nand();
    test_glitch();
    test_mode();
    test_collision();
    test_reset_mid();
    test_oe();
    test_param();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
